// File: rtl/syn_spike_dispatcher.sv
// Spike FIFO and weight-read issuer feeding the neuron accumulator with tagged weights.
// Optional SYN_DISP_DROP_CNT_EN enables the saturating dropped-spike counter.
module syn_spike_dispatcher #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              spk_valid,
    input  logic [ADDR_W-1:0] spk_addr,
    input  logic              acc_busy,
    output logic [15:0]       iADDR,
    output logic              R_EN,
    output logic              W_EN,
    input  logic [15:0]       w_in,
    output logic              w_valid,
    output logic [ADDR_W-1:0] w_addr,
    output logic [15:0]       w_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, FLUSH} state_t;

    state_t                         state_q;
    logic [ADDR_W-1:0]              mem_q [DEPTH];
    logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [ADDR_W-1:0]              raddr_q;
    logic                           ren_q;
    logic [RD_LAT-1:0]              vld_pipe_q;
    logic [RD_LAT-1:0][ADDR_W-1:0]  tag_pipe_q;
    logic                           wv_q, full_q, empty_q;
    logic [ADDR_W-1:0]              wa_q;
    logic [15:0]                    wd_q;
    logic                           ignore, push, pop;

    // The cycle after kill falls still counts as flush: no push, no issue.
    always_comb begin
        ignore = kill || (state_q == FLUSH);
        pop    = !ignore && (cnt_q != '0) && !acc_busy;
        push   = !ignore && spk_valid && (cnt_q != CW'(DEPTH));
        cnt_d  = cnt_q;
        if (kill) cnt_d = '0;
        else      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= spk_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            raddr_q    <= '0;
            ren_q      <= 1'b0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            wv_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
            if (kill) begin
                state_q    <= FLUSH;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                ren_q      <= 1'b0;
                vld_pipe_q <= '0;
                wv_q       <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    raddr_q  <= mem_q[rd_ptr_q];
                end
                ren_q <= pop;
                if (state_q == FLUSH)            state_q <= IDLE;
                else if (pop)                    state_q <= (cnt_d == '0) ? IDLE : ISSUE;
                else if (acc_busy && cnt_d != '0) state_q <= HOLD;
                else                             state_q <= IDLE;
                // Tag pipe is fed from the issue register so its tail lines up with w_in.
                vld_pipe_q[0] <= ren_q;
                tag_pipe_q[0] <= raddr_q;
                for (int i = RD_LAT-1; i > 0; i--) begin
                    vld_pipe_q[i] <= vld_pipe_q[i-1];
                    tag_pipe_q[i] <= tag_pipe_q[i-1];
                end
                wv_q <= vld_pipe_q[RD_LAT-1];
                if (vld_pipe_q[RD_LAT-1]) begin
                    wa_q <= tag_pipe_q[RD_LAT-1];
                    wd_q <= w_in;
                end
            end
        end
    end

`ifdef SYN_DISP_DROP_CNT_EN
    logic [CNT_W-1:0] drop_q;
    logic             drop;

    assign drop = !ignore && spk_valid && (cnt_q == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       drop_q <= '0;
        else if (drop && drop_q != '1)  drop_q <= drop_q + CNT_W'(1);
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign iADDR      = {{(16-ADDR_W){1'b0}}, raddr_q};
    assign R_EN       = ren_q;
    assign W_EN       = 1'b0;
    assign w_valid    = wv_q;
    assign w_addr     = wa_q;
    assign w_data     = wd_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
endmodule

// File: tb/tb_syn_spike_dispatcher.sv
// Bench for syn_spike_dispatcher: queue/timestamp model checked every cycle plus pinned literals.
module tb_syn_spike_dispatcher;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        kill = 1'b0, spk_valid = 1'b0, acc_busy = 1'b0;
    logic [6:0]  spk_addr = '0;
    logic [15:0] iADDR, w_in, w_data, s1;
    logic        R_EN, W_EN, w_valid, fifo_full, fifo_empty;
    logic [6:0]  w_addr;
    logic [7:0]  drop_cnt;

    int total = 0, bad = 0;
    int nwv = 0;
    logic [6:0] last_wa = '0;

    syn_spike_dispatcher dut (
        .clk(clk), .rst(rst), .kill(kill), .spk_valid(spk_valid), .spk_addr(spk_addr),
        .acc_busy(acc_busy), .iADDR(iADDR), .R_EN(R_EN), .W_EN(W_EN), .w_in(w_in),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wfn(input logic [15:0] a);
        return 16'hA000 | a;
    endfunction

    // Synapse model: address register then BRAM register.
    always @(posedge clk) begin
        s1   <= wfn(iADDR);
        w_in <= s1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_drop(input int d);
`ifdef SYN_DISP_DROP_CNT_EN
        return d;
`else
        return 0;
`endif
    endfunction

    // Model: FIFO as a queue, in-flight reads as (due edge, addr) records.
    typedef struct { int due; logic [6:0] a; } inf_t;
    logic [6:0] mq [$];
    inf_t       inf [$];
    int         cyc = 0, m_drop = 0;
    bit         m_flush = 0, m_ren = 0, m_wv = 0;
    logic [6:0] m_iaddr = '0, m_wa = '0;

    always begin
        bit k, sv, b, ign, iss;
        logic [6:0] sa;
        int n;
        @(posedge clk);
        k = kill; sv = spk_valid; b = acc_busy; sa = spk_addr;
        if (!rst) begin
            mq.delete(); inf.delete();
            m_flush = 0; m_drop = 0; m_ren = 0; m_wv = 0;
            #1;
            chk("rst_ren", R_EN, 0);
            chk("rst_iaddr", iADDR, 0);
            chk("rst_wv", w_valid, 0);
            chk("rst_waddr", w_addr, 0);
            chk("rst_wdata", w_data, 0);
            chk("rst_full", fifo_full, 0);
            chk("rst_empty", fifo_empty, 1);
            chk("rst_drop", drop_cnt, 0);
        end else begin
            cyc++;
            m_wv = 0;
            if (k) begin
                mq.delete(); inf.delete();
                m_ren = 0; m_flush = 1;
            end else begin
                ign = m_flush; m_flush = 0;
                n = mq.size();
                iss = !ign && n > 0 && !b;
                m_ren = iss;
                if (inf.size() > 0 && inf[0].due == cyc) begin
                    m_wv = 1; m_wa = inf[0].a; void'(inf.pop_front());
                end
                if (iss) begin
                    m_iaddr = mq.pop_front();
                    inf.push_back('{cyc + RD_LAT + 1, m_iaddr});
                end
                if (sv && !ign) begin
                    if (n < DEPTH) mq.push_back(sa);
                    else if (m_drop < 255) m_drop++;
                end
            end
            #1;
            chk("ren", R_EN, m_ren);
            if (m_ren) chk("iaddr", iADDR, {9'b0, m_iaddr});
            chk("wv", w_valid, m_wv);
            if (m_wv) begin
                chk("waddr", w_addr, m_wa);
                chk("wdata", w_data, wfn({9'b0, m_wa}));
            end
            chk("full", fifo_full, mq.size() == DEPTH);
            chk("empty", fifo_empty, mq.size() == 0);
            chk("drop", drop_cnt, exp_drop(m_drop));
            chk("wen", W_EN, 0);
            if (w_valid) begin nwv++; last_wa = w_addr; end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [6:0] a);
        spk_valid = 1'b1; spk_addr = a;
        @(negedge clk);
        spk_valid = 1'b0;
    endtask

    initial begin
        int n0;
        cyc_n(3);
        // Single spike: pinned latency and data.
        rst = 1'b1;
        push(7'd5);
        @(posedge clk); #1;
        chk("t1_ren", R_EN, 1);
        chk("t1_iaddr", iADDR, 16'd5);
        @(posedge clk); @(posedge clk); #1;
        chk("t1_wv_early", w_valid, 0);
        @(posedge clk); #1;
        chk("t1_wv", w_valid, 1);
        chk("t1_waddr", w_addr, 7'd5);
        chk("t1_wdata", w_data, 16'hA005);
        cyc_n(4);

        // Fill under stall, drop, then drain in order.
        acc_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(7'(i));
        chk("t2_full", fifo_full, 1);
        chk("t2_ren", R_EN, 0);
        push(7'd99);
        chk("t2_drop", drop_cnt, exp_drop(1));
        n0 = nwv;
        acc_busy = 1'b0;
        cyc_n(25);
        chk("t2_count", nwv - n0, 16);
        chk("t2_last", last_wa, 7'd15);

        // Stream with a 3-cycle stall.
        n0 = nwv;
        for (int i = 0; i < 10; i++) begin
            spk_valid = 1'b1; spk_addr = 7'(20 + i);
            acc_busy = (i >= 4 && i < 7);
            @(posedge clk); #1;
            if (i == 4) chk("t3_stop", R_EN, 0);
            @(negedge clk);
        end
        spk_valid = 1'b0; acc_busy = 1'b0;
        cyc_n(15);
        chk("t3_count", nwv - n0, 10);
        chk("t3_last", last_wa, 7'd29);

        // Kill with 6 queued and 2 in flight.
        acc_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(7'(50 + i));
        acc_busy = 1'b0;
        cyc_n(2);
        kill = 1'b1; acc_busy = 1'b1;
        n0 = nwv;
        @(posedge clk); #1;
        chk("t4_empty", fifo_empty, 1);
        cyc_n(2);
        kill = 1'b0; acc_busy = 1'b0;
        cyc_n(8);
        chk("t4_none", nwv - n0, 0);
        push(7'd7);
        cyc_n(8);
        chk("t4_after", nwv - n0, 1);
        chk("t4_addr", last_wa, 7'd7);

        // Full FIFO with simultaneous push and pop, then saturating drops.
        acc_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(7'(60 + i));
        n0 = nwv;
        acc_busy = 1'b0; spk_valid = 1'b1; spk_addr = 7'd100;
        @(posedge clk); #1;
        chk("t5_notfull", fifo_full, 0);
        chk("t5_ren", R_EN, 1);
        chk("t5_drop", drop_cnt, exp_drop(2));
        @(negedge clk);
        acc_busy = 1'b1;
        push(7'd101);
        chk("t5_refull", fifo_full, 1);
        spk_valid = 1'b1; spk_addr = 7'd102;
        cyc_n(300);
        spk_valid = 1'b0;
        cyc_n(1);
        chk("t5_sat", drop_cnt, exp_drop(255));
        acc_busy = 1'b0;
        cyc_n(25);
        chk("t5_count", nwv - n0, 17);
        chk("t5_last", last_wa, 7'd101);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) push(7'(110 + i));
        rst = 1'b0;
        cyc_n(2);
        chk("t6_empty", fifo_empty, 1);
        chk("t6_drop", drop_cnt, 0);
        rst = 1'b1;
        cyc_n(6);
        n0 = nwv;
        push(7'd9);
        cyc_n(8);
        chk("t6_after", nwv - n0, 1);
        chk("t6_addr", last_wa, 7'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
